fse_lms_update: RTL and testbench
=================================

# fse_lms_update

LMS coefficient engine for the fractionally spaced equalizer. It observes the equalizer input samples and the transposed-FIR output, then computes the error against a training symbol or a slicer decision. It adapts the taps and drives the packed coefficient bus that the FIR loads on every enabled cycle. It sits beside the FIR in the FSE datapath and closes the adaptation loop.

## Interface
- `NBin`, 8: input sample bits; `NBFin`, 5: input fractional bits
- `NBy`, 8: FIR output / training symbol bits; `NBFy`, 5: their fractional bits
- `Ncoeff`, 9: number of taps; `NBcoeff`, 7: coefficient bits; `NBFcoeff`, 5: coefficient fractional bits
- `NBerr`, 8: error bits, with `NBFy` fractional bits
- `OS`, 2: samples per symbol
- `Y_LAT`, 2: enabled cycles from `x` presented to `y` reflecting it
- `MU_SHIFT`, 4: step size, mu = 2^-MU_SHIFT
- `TRAIN_LEN`, 256: symbol updates spent in training
- `LEAK_SHIFT`, 8: leakage factor 2^-LEAK_SHIFT (used only with the leakage macro)
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `i_enable`  in  1  sample strobe, the same strobe that feeds the FIR
- `x`  in  NBin  equalizer input sample, signed
- `y`  in  NBy  FIR output, signed
- `i_train_sym`  in  NBy  known symbol, signed; sampled in TRAIN on symbol phase
- `i_start`  in  1  start or restart adaptation
- `i_freeze`  in  1  inhibit updates, state held
- `coeff`  out  Ncoeff*NBcoeff  packed taps; bits NBcoeff*(i+1)-1 -: NBcoeff hold tap i
- `o_coeff_valid`  out  1  one-cycle pulse after each tap update
- `o_err`  out  NBerr  last computed error, signed
- `o_mode`  out  2  00 IDLE, 01 TRAIN, 10 DD

## Operation
- Reset values:
  - Taps: tap (Ncoeff-1)/2 = 2^NBFcoeff (1.0), all others 0.
  - Regressor line, phase counter and train counter: 0.
  - `o_err` 0, `o_coeff_valid` 0, `o_mode` 00.
- Regressor:
  - On each `i_enable`, `x` shifts into a delay line of Ncoeff+Y_LAT entries.
  - The regressor for tap i is the entry delayed i+Y_LAT samples, so tap i is matched to the FIR's i-sample delay.
- Phase: a counter modulo OS advances on each `i_enable`. Phase 0 is the symbol instant; updates occur only there.
- FSM:
  - IDLE: no updates. Goes to TRAIN on `i_start`.
  - TRAIN: reference d = `i_train_sym`. Goes to DD after TRAIN_LEN updates.
  - DD: d = +1.0 if `y` >= 0, else -1.0; the value 1.0 is 2^NBFy.
  - `i_start` in TRAIN or DD reloads the reset taps, clears the counters and enters TRAIN.
  - `i_start` has priority over any update in the same cycle.
- Error:
  - e = d - y, computed at NBy+1 bits, then saturated to NBerr at NBFy fractional bits.
  - `o_err` registers e on each update cycle.
- Update, per tap:
  - p = e * r_i, at NBerr+NBin bits with NBFy+NBFin fractional bits.
  - delta = p >>> (NBFy+NBFin-NBFcoeff+MU_SHIFT); arithmetic shift, floor.
  - w_i <= sat(w_i + delta) to [-2^(NBcoeff-1), 2^(NBcoeff-1)-1].
- Update condition: `i_enable` AND phase==0 AND mode is TRAIN or DD AND NOT `i_freeze`.
- Freeze: `i_freeze` holds the taps, both counters' training progress and the mode. The phase counter keeps running.

## Timing
- Taps, `o_err` and `o_coeff_valid` register on the update cycle. New taps are visible on `coeff` the cycle after.
- `o_coeff_valid` is high exactly one cycle per update; it is never high in IDLE or while frozen.
- The DD transition takes effect on the cycle after the TRAIN_LEN-th update. That update itself uses the training reference.
- Reset asserted mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.
- `i_enable` low: no state changes except `i_start` handling.

## Configuration
- `FSE_LMS_LEAKAGE_EN` defined: each update uses w_i + delta - (w_i >>> LEAK_SHIFT) before saturation.
- `FSE_LMS_LEAKAGE_EN` undefined: plain LMS, and `LEAK_SHIFT` is unused.

## Structure
- Shared package `fse_pkg`:
  - Mode encodings: IDLE/TRAIN/DD.
  - Saturation width helpers.
  - The 1.0 constants for coefficients and symbols.
- One sub-module, `fse_lms_tap`, instantiated Ncoeff times. It holds one tap register and does the multiply, shift, optional leakage and saturated add, with its reset value as a parameter.

## Test plan
- Reset check:
  - Reset, then release → `coeff` = 32<<28, `o_mode` = 00, `o_err` = 0.
  - 20 enabled cycles without `i_start` → `coeff` unchanged.
- TRAIN increment:
  - Stimulus: `i_start`, x = 32 constant, y = 0, `i_train_sym` = 32.
  - Response: e = 32 and delta = 2 on every tap, so the center tap reads 34 and the others 2 after the first update.
  - `o_coeff_valid` pulses every 2 enabled cycles.
- TRAIN → DD: override TRAIN_LEN = 4 → `o_mode` = 10 after the 4th update.
- DD rounding: y = -8, x = 32 → d = -32, e = -24, delta = -2 (floor of -1.5).
- Saturation: drive e = 32 and x = 32 repeatedly → taps stop at 63. Reverse the sign → taps stop at -64.
- Freeze and restart:
  - `i_freeze` high → taps, mode and `o_coeff_valid` all static.
  - `i_start` during DD → taps return to reset values and `o_mode` = 01.
  - `reset` pulse mid-TRAIN → all outputs at reset values immediately.
- Leakage (with `FSE_LMS_LEAKAGE_EN`, LEAK_SHIFT = 1): center tap 32 with e = 0 → 16 after one update.

Source files
------------

// File: rtl/fse_lms_update_pkg.sv
// -----------------------------------------------------------------------------
// fse_pkg
// Shared definitions for the fractionally spaced equalizer LMS engine.
//   mode_t    : adaptation mode encodings (IDLE / TRAIN / DD)
//   sat_max   : largest value of a signed field of a given width
//   sat_min   : smallest value of a signed field of a given width
//   fixed_one : the value 1.0 for a given number of fractional bits
//   COEFF_ONE / SYM_ONE : 1.0 in the default coefficient / symbol formats
// -----------------------------------------------------------------------------
package fse_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_TRAIN = 2'b01,
    MODE_DD    = 2'b10
  } mode_t;

  function automatic int sat_max(input int nb);
    return (1 << (nb - 1)) - 1;
  endfunction

  function automatic int sat_min(input int nb);
    return -(1 << (nb - 1));
  endfunction

  function automatic int fixed_one(input int nbf);
    return 1 << nbf;
  endfunction

  localparam int COEFF_ONE = fixed_one(5);
  localparam int SYM_ONE   = fixed_one(5);

endpackage

// File: rtl/fse_lms_update_if.sv
// -----------------------------------------------------------------------------
// fse_lms_update_if
// Sample, reference and control inputs of the LMS engine plus its coefficient
// bus and status outputs.
//   master : drives i_enable, x, y, i_train_sym, i_start, i_freeze
//   slave  : the LMS engine; drives coeff, o_coeff_valid, o_err, o_mode
// -----------------------------------------------------------------------------
interface fse_lms_update_if #(
  parameter int NBin    = 8,
  parameter int NBy     = 8,
  parameter int Ncoeff  = 9,
  parameter int NBcoeff = 7,
  parameter int NBerr   = 8
);

  logic                        i_enable;
  logic signed [NBin-1:0]      x;
  logic signed [NBy-1:0]       y;
  logic signed [NBy-1:0]       i_train_sym;
  logic                        i_start;
  logic                        i_freeze;
  logic [Ncoeff*NBcoeff-1:0]   coeff;
  logic                        o_coeff_valid;
  logic signed [NBerr-1:0]     o_err;
  logic [1:0]                  o_mode;

  modport master (
    output i_enable, x, y, i_train_sym, i_start, i_freeze,
    input  coeff, o_coeff_valid, o_err, o_mode
  );

  modport slave (
    input  i_enable, x, y, i_train_sym, i_start, i_freeze,
    output coeff, o_coeff_valid, o_err, o_mode
  );

endinterface

// File: rtl/fse_lms_update_tap.sv
// -----------------------------------------------------------------------------
// fse_lms_tap
// One adaptive tap: w <= sat(w + ((e * r) >>> SHIFT) [- (w >>> LEAK_SHIFT)]).
// Optional leakage is enabled by defining FSE_LMS_LEAKAGE_EN.
//   clk, reset : clock, asynchronous active-high reset (w <= RESET_VAL)
//   load       : reload RESET_VAL (restart), has priority over update
//   update     : apply one LMS step this cycle
//   e          : error sample, signed
//   r          : regressor sample matched to this tap, signed
//   w          : current tap value, signed
// -----------------------------------------------------------------------------
module fse_lms_tap
  import fse_pkg::*;
#(
  parameter int                        NBerr      = 8,
  parameter int                        NBin       = 8,
  parameter int                        NBcoeff    = 7,
  parameter int                        SHIFT      = 9,
  parameter int                        LEAK_SHIFT = 8,
  parameter logic signed [NBcoeff-1:0] RESET_VAL  = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      update,
  input  logic signed [NBerr-1:0]   e,
  input  logic signed [NBin-1:0]    r,
  output logic signed [NBcoeff-1:0] w
);

  localparam int PW = NBerr + NBin;
  localparam int SW = PW + 1;

`ifdef FSE_LMS_LEAKAGE_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  logic signed [PW-1:0]      p;
  logic signed [PW-1:0]      delta;
  logic signed [SW-1:0]      leak;
  logic signed [SW-1:0]      sum;
  logic signed [NBcoeff-1:0] w_next;

  // Full-precision product, floor-shifted step, then clamp to the tap range.
  // The sum is one bit wider than the product so it can never wrap.
  always_comb begin
    p      = PW'(e) * PW'(r);
    delta  = p >>> SHIFT;
    leak   = LEAK_ON ? SW'(w >>> LEAK_SHIFT) : '0;
    sum    = SW'(w) + SW'(delta) - leak;
    w_next = NBcoeff'(sum);
    if (sum > SW'(sat_max(NBcoeff))) begin
      w_next = NBcoeff'(sat_max(NBcoeff));
    end else if (sum < SW'(sat_min(NBcoeff))) begin
      w_next = NBcoeff'(sat_min(NBcoeff));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w <= RESET_VAL;
    end else if (load) begin
      w <= RESET_VAL;
    end else if (update) begin
      w <= w_next;
    end
  end

endmodule

// File: rtl/fse_lms_update.sv
// -----------------------------------------------------------------------------
// fse_lms_update
// LMS coefficient engine for the fractionally spaced equalizer. Tracks the
// FIR input samples, forms the error against a training symbol or a slicer
// decision at each symbol instant and adapts Ncoeff taps.
// Optional leakage: define FSE_LMS_LEAKAGE_EN (default build has it off).
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : fse_lms_update_if.slave
//           in  i_enable, x, y, i_train_sym, i_start, i_freeze
//           out coeff (tap i at NBcoeff*(i+1)-1 -: NBcoeff), o_coeff_valid,
//               o_err, o_mode (00 IDLE, 01 TRAIN, 10 DD)
// -----------------------------------------------------------------------------
module fse_lms_update
  import fse_pkg::*;
#(
  parameter int NBin       = 8,
  parameter int NBFin      = 5,
  parameter int NBy        = 8,
  parameter int NBFy       = 5,
  parameter int Ncoeff     = 9,
  parameter int NBcoeff    = 7,
  parameter int NBFcoeff   = 5,
  parameter int NBerr      = 8,
  parameter int OS         = 2,
  parameter int Y_LAT      = 2,
  parameter int MU_SHIFT   = 4,
  parameter int TRAIN_LEN  = 256,
  parameter int LEAK_SHIFT = 8
) (
  input  logic              clk,
  input  logic              reset,
  fse_lms_update_if.slave   bus
);

  // The current x counts as the zero-delay entry, so only the older samples
  // need registers; tap i reads the sample delayed i+Y_LAT (Y_LAT >= 1).
  localparam int LINE_LEN  = Ncoeff + Y_LAT - 1;
  localparam int PH_W      = (OS > 1) ? $clog2(OS) : 1;
  localparam int TC_W      = $clog2(TRAIN_LEN + 1);
  localparam int UPD_SHIFT = NBFy + NBFin - NBFcoeff + MU_SHIFT;

  logic signed [NBin-1:0]    line [LINE_LEN];
  logic [PH_W-1:0]           phase;
  logic [TC_W-1:0]           train_cnt;
  mode_t                     mode, mode_next;
  logic                      update;
  logic                      last_train;
  logic signed [NBy-1:0]     d;
  logic signed [NBy:0]       e_full;
  logic signed [NBerr-1:0]   e;
  logic                      valid_q;
  logic signed [NBerr-1:0]   err_q;
  logic signed [NBcoeff-1:0] taps [Ncoeff];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LINE_LEN; k++) line[k] <= '0;
    end else if (bus.i_enable) begin
      line[0] <= bus.x;
      for (int k = 1; k < LINE_LEN; k++) line[k] <= line[k-1];
    end
  end

  // Symbol phase keeps running while frozen; the training count only moves
  // on real TRAIN updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= '0;
      train_cnt <= '0;
    end else if (bus.i_start) begin
      phase     <= '0;
      train_cnt <= '0;
    end else begin
      if (bus.i_enable) begin
        phase <= (phase == PH_W'(OS - 1)) ? '0 : phase + 1'b1;
      end
      if (update && mode == MODE_TRAIN) begin
        train_cnt <= train_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode <= MODE_IDLE;
    else       mode <= mode_next;
  end

  // Restart wins over any update in the same cycle.
  always_comb begin
    update     = bus.i_enable && (phase == '0) && (mode != MODE_IDLE) &&
                 !bus.i_freeze && !bus.i_start;
    last_train = (train_cnt == TC_W'(TRAIN_LEN - 1));
    mode_next  = mode;
    case (mode)
      MODE_IDLE:  if (bus.i_start) mode_next = MODE_TRAIN;
      MODE_TRAIN: begin
        if (bus.i_start)               mode_next = MODE_TRAIN;
        else if (update && last_train) mode_next = MODE_DD;
      end
      MODE_DD:    if (bus.i_start) mode_next = MODE_TRAIN;
      default:    mode_next = MODE_IDLE;
    endcase
  end

  // Reference is the training symbol or a +/-1.0 slicer decision on y.
  always_comb begin
    if (mode == MODE_TRAIN) begin
      d = bus.i_train_sym;
    end else begin
      d = (bus.y >= 0) ? NBy'(fixed_one(NBFy)) : NBy'(-fixed_one(NBFy));
    end
    e_full = (NBy+1)'(d) - (NBy+1)'(bus.y);
    e      = NBerr'(e_full);
    if (int'(e_full) > sat_max(NBerr)) begin
      e = NBerr'(sat_max(NBerr));
    end else if (int'(e_full) < sat_min(NBerr)) begin
      e = NBerr'(sat_min(NBerr));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      valid_q <= update;
      if (update) err_q <= e;
    end
  end

  for (genvar i = 0; i < Ncoeff; i++) begin : g_tap
    localparam logic signed [NBcoeff-1:0] RST_W =
      (i == (Ncoeff - 1) / 2) ? NBcoeff'(fixed_one(NBFcoeff)) : '0;

    fse_lms_tap #(
      .NBerr      (NBerr),
      .NBin       (NBin),
      .NBcoeff    (NBcoeff),
      .SHIFT      (UPD_SHIFT),
      .LEAK_SHIFT (LEAK_SHIFT),
      .RESET_VAL  (RST_W)
    ) u_tap (
      .clk    (clk),
      .reset  (reset),
      .load   (bus.i_start),
      .update (update),
      .e      (e),
      .r      (line[i + Y_LAT - 1]),
      .w      (taps[i])
    );

    assign bus.coeff[NBcoeff*(i+1)-1 -: NBcoeff] = taps[i];
  end

  assign bus.o_coeff_valid = valid_q;
  assign bus.o_err         = err_q;
  assign bus.o_mode        = mode;

endmodule

// File: tb/tb_fse_lms_update.sv
// -----------------------------------------------------------------------------
// tb_fse_lms_update
// Self-checking bench for fse_lms_update (TRAIN_LEN shortened to 4). A
// behavioural model tracks sample history, symbol phase, mode and taps with
// plain integer arithmetic; every cycle the DUT outputs are compared to it.
// -----------------------------------------------------------------------------
module tb_fse_lms_update;

  localparam int NBIN = 8, NBFIN = 5, NBY = 8, NBFY = 5;
  localparam int NC = 9, NBC = 7, NBFC = 5, NBE = 8;
  localparam int OS_TB = 2, YL = 2, MU = 4, TL = 4, LS = 8;
  localparam int HL = NC + YL;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  fse_lms_update_if #(
    .NBin(NBIN), .NBy(NBY), .Ncoeff(NC), .NBcoeff(NBC), .NBerr(NBE)
  ) bus ();

  fse_lms_update #(
    .NBin(NBIN), .NBFin(NBFIN), .NBy(NBY), .NBFy(NBFY), .Ncoeff(NC),
    .NBcoeff(NBC), .NBFcoeff(NBFC), .NBerr(NBE), .OS(OS_TB), .Y_LAT(YL),
    .MU_SHIFT(MU), .TRAIN_LEN(TL), .LEAK_SHIFT(LS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  int m_w [NC];
  int m_h [HL];
  int m_phase, m_tcnt, m_mode, m_err, m_valid;

  function automatic int floorShift(input int v, input int s);
    int q;
    q = 1 << s;
    if (v >= 0) return v / q;
    return -((-v + q - 1) / q);
  endfunction

  function automatic int clampInt(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NC; i++) m_w[i] = (i == (NC - 1) / 2) ? 32 : 0;
    for (int k = 0; k < HL; k++) m_h[k] = 0;
    m_phase = 0; m_tcnt = 0; m_mode = 0; m_err = 0; m_valid = 0;
  endtask

  // One clock of the reference behaviour; inputs are integer sample values.
  task automatic modelStep(input bit en, input int xv, input int yv,
                           input int tv, input bit st, input bit fr);
    int d, e, delta, nw;
    bit upd;
    m_valid = 0;
    upd = en && !st && (m_phase == 0) && (m_mode != 0) && !fr;
    if (en) begin
      for (int k = HL - 1; k > 0; k--) m_h[k] = m_h[k-1];
      m_h[0] = xv;
    end
    if (st) begin
      for (int i = 0; i < NC; i++) m_w[i] = (i == (NC - 1) / 2) ? 32 : 0;
      m_phase = 0; m_tcnt = 0; m_mode = 1;
    end else begin
      if (upd) begin
        if (m_mode == 1) d = tv;
        else             d = (yv >= 0) ? 32 : -32;
        e = clampInt(d - yv, -128, 127);
        for (int i = 0; i < NC; i++) begin
          delta = floorShift(e * m_h[i + YL], NBFY + NBFIN - NBFC + MU);
          nw = m_w[i] + delta;
`ifdef FSE_LMS_LEAKAGE_EN
          nw = nw - floorShift(m_w[i], LS);
`endif
          m_w[i] = clampInt(nw, -64, 63);
        end
        m_err = e;
        m_valid = 1;
        if (m_mode == 1) begin
          m_tcnt++;
          if (m_tcnt == TL) m_mode = 2;
        end
      end
      if (en) m_phase = (m_phase + 1) % OS_TB;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [NC*NBC-1:0] ec;
    logic [7:0] ee;
    logic [1:0] em;
    for (int i = 0; i < NC; i++) ec[NBC*i +: NBC] = NBC'(m_w[i]);
    ee = 8'(m_err);
    em = 2'(m_mode);
    checkOutput({tag, "_coeff"}, {1'b0, bus.coeff}, {1'b0, ec});
    checkOutput({tag, "_mode"},  {62'b0, bus.o_mode}, {62'b0, em});
    checkOutput({tag, "_err"},   {56'b0, bus.o_err}, {56'b0, ee});
    checkOutput({tag, "_valid"}, {63'b0, bus.o_coeff_valid}, {63'b0, 1'(m_valid)});
  endtask

  task automatic applyStimulus(input bit en, input logic [7:0] xv,
                               input logic [7:0] yv, input logic [7:0] tv,
                               input bit st, input bit fr, input string tag);
    @(negedge clk);
    bus.i_enable    = en;
    bus.x           = xv;
    bus.y           = yv;
    bus.i_train_sym = tv;
    bus.i_start     = st;
    bus.i_freeze    = fr;
    modelStep(en, int'($signed(xv)), int'($signed(yv)), int'($signed(tv)), st, fr);
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  function automatic logic [6:0] tapOf(input int i);
    logic [NC*NBC-1:0] c;
    c = bus.coeff;
    return c[NBC*i +: NBC];
  endfunction

  initial begin
    bus.i_enable = 1'b0; bus.x = '0; bus.y = '0; bus.i_train_sym = '0;
    bus.i_start = 1'b0; bus.i_freeze = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkAll("reset");
    checkOutput("reset_center", {1'b0, bus.coeff}, 64'd32 << 28);

    for (int k = 0; k < 20; k++) applyStimulus(1, 8'd32, 8'd0, 8'd32, 0, 0, "idle");

    applyStimulus(1, 8'd32, 8'd0, 8'd32, 1, 0, "start");
    applyStimulus(1, 8'd32, 8'd0, 8'd32, 0, 0, "train1");
    checkOutput("train1_center", {57'b0, tapOf(4)}, 64'd34);
    checkOutput("train1_tap0",   {57'b0, tapOf(0)}, 64'd2);
    for (int k = 0; k < 6; k++) applyStimulus(1, 8'd32, 8'd0, 8'd32, 0, 0, "train");
    checkOutput("to_dd_mode", {62'b0, bus.o_mode}, 64'd2);

    for (int k = 0; k < 80; k++) applyStimulus(1, 8'd32, 8'd0, 8'd0, 0, 0, "sat_hi");
    checkOutput("sat_hi_center", {57'b0, tapOf(4)}, 64'd63);
    checkOutput("sat_hi_tap0",   {57'b0, tapOf(0)}, 64'd63);

    for (int k = 0; k < 2; k++) applyStimulus(1, 8'd32, 8'hF8, 8'd0, 0, 0, "dd_round");
    checkOutput("dd_round_center", {57'b0, tapOf(4)}, 64'd61);
    checkOutput("dd_round_err",    {56'b0, bus.o_err}, 64'hE8);

    for (int k = 0; k < 140; k++) applyStimulus(1, 8'd32, 8'hFF, 8'd0, 0, 0, "sat_lo");
    checkOutput("sat_lo_center", {57'b0, tapOf(4)}, 64'h40);

    for (int k = 0; k < 10; k++)
      applyStimulus(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1, "freeze");

    applyStimulus(1, 8'd32, 8'd0, 8'd0, 1, 0, "restart");
    checkOutput("restart_mode", {62'b0, bus.o_mode}, 64'd1);
    checkOutput("restart_coeff", {1'b0, bus.coeff}, 64'd32 << 28);

    for (int k = 0; k < 5; k++)
      applyStimulus(1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("async_rst");
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(3) != 0), 8'($urandom), 8'($urandom),
                    8'($urandom), ($urandom_range(63) == 0),
                    ($urandom_range(7) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
